// File: rtl/act_rf_ni_read_ctrl_pkg.sv
// Shared widths, encodings and the response-entry layout for the NI read path
// into the output-activation register file.
`timescale 1ns/1ps
package act_rf_ni_read_ctrl_pkg;
    localparam int ACT_NO_W      = 8;
    localparam int ACT_W         = 8;
    localparam int COMP_EN_W     = 2;
    localparam int RSP_DEPTH_DEF = 4;

    localparam logic [COMP_EN_W-1:0] COMP_EN_IDLE = '0;

    typedef struct packed {
        logic [ACT_NO_W-1:0] addr;
        logic [ACT_W-1:0]    data;
    } rsp_entry_t;
endpackage

// File: rtl/act_rsp_fifo.sv
// In-order response FIFO with synchronous reset; a push and a pop may share a
// cycle at any occupancy, including full.
`timescale 1ns/1ps
module act_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_rd;

    // Extra pointer bit separates full from empty; DEPTH is a power of two so
    // the low bits wrap on their own.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && full && !do_rd));
endmodule

// File: rtl/act_rf_ni_read_ctrl.sv
// Arbitrates NI reads onto the output-activation RF read port (ADD has priority)
// and returns the RF data, tagged with its address, through a response FIFO.
`timescale 1ns/1ps
module act_rf_ni_read_ctrl
    import act_rf_ni_read_ctrl_pkg::*;
#(
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ni_rd_req_valid,
    input  logic [ACT_NO_W-1:0]  ni_rd_req_addr,
    output logic                 ni_rd_req_ready,
    input  logic [COMP_EN_W-1:0] comp_en_add,
    output logic                 ni_read_rqst,
    output logic [ACT_NO_W-1:0]  ni_read_addr,
    input  logic [ACT_W-1:0]     out_act_read_data,
    output logic                 ni_rd_rsp_valid,
    output logic [ACT_W-1:0]     ni_rd_rsp_data,
    output logic [ACT_NO_W-1:0]  ni_rd_rsp_addr,
    input  logic                 ni_rd_rsp_ready
);
    localparam int OCW = $clog2(RSP_DEPTH + 1);
    localparam logic [OCW-1:0] OCC_MAX = OCW'(RSP_DEPTH);
    localparam logic [OCW-1:0] OCC_ONE = OCW'(1);

    logic                pend;
    logic [ACT_NO_W-1:0] pend_addr;
    logic                inflight;
    logic [ACT_NO_W-1:0] inflight_addr;
    logic [OCW-1:0]      occ;
    logic                grant;
    logic                accept;
    logic                pop;
    logic                fifo_empty;
    rsp_entry_t          wr_entry;
    rsp_entry_t          head;

    // Both NI channels: a transfer happens in exactly the cycle valid && ready
    // are high; valid never waits on ready, and the response head is held while
    // valid && !ready.
    assign grant  = pend && (comp_en_add == COMP_EN_IDLE);
    assign pop    = ni_rd_rsp_valid && ni_rd_rsp_ready;
    assign accept = ni_rd_req_valid && ni_rd_req_ready;

    // occ counts every accepted read not yet popped (pending, in flight or
    // buffered), so capping it at RSP_DEPTH keeps the FIFO from overflowing.
    assign ni_rd_req_ready = !rst && (!pend || grant) && ((occ < OCC_MAX) || pop);

    assign ni_read_rqst = pend && !rst;
    assign ni_read_addr = ni_read_rqst ? pend_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend          <= 1'b0;
            pend_addr     <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            occ           <= '0;
        end else begin
            if (accept) begin
                pend      <= 1'b1;
                pend_addr <= ni_rd_req_addr;
            end else if (grant) begin
                pend <= 1'b0;
            end
            inflight <= grant;
            if (grant) begin
                inflight_addr <= pend_addr;
            end
            case ({accept, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // RF data arrives the cycle after the grant, alongside inflight_addr.
    assign wr_entry.addr = inflight_addr;
    assign wr_entry.data = out_act_read_data;

    act_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(rsp_entry_t))
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty)
    );

    assign ni_rd_rsp_valid = !rst && !fifo_empty;
    assign ni_rd_rsp_data  = ni_rd_rsp_valid ? head.data : '0;
    assign ni_rd_rsp_addr  = ni_rd_rsp_valid ? head.addr : '0;

    occ_bound_chk: assert property (@(posedge clk) disable iff (rst) occ <= OCC_MAX);
endmodule

// File: tb/tb_act_rf_ni_read_ctrl.sv
// Directed and randomized bench for act_rf_ni_read_ctrl; the RF is modelled as
// data = addr ^ 0xA5-style pattern (addr ^ 0xA0), read one cycle after a grant.
`timescale 1ns/1ps
module tb_act_rf_ni_read_ctrl;
    import act_rf_ni_read_ctrl_pkg::*;

    localparam int RSP_DEPTH = 4;
    localparam logic [COMP_EN_W-1:0] ADD_ACTIVE = 2'd1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ni_rd_req_valid;
    logic [ACT_NO_W-1:0]  ni_rd_req_addr;
    logic                 ni_rd_req_ready;
    logic [COMP_EN_W-1:0] comp_en_add;
    logic                 ni_read_rqst;
    logic [ACT_NO_W-1:0]  ni_read_addr;
    logic [ACT_W-1:0]     out_act_read_data;
    logic                 ni_rd_rsp_valid;
    logic [ACT_W-1:0]     ni_rd_rsp_data;
    logic [ACT_NO_W-1:0]  ni_rd_rsp_addr;
    logic                 ni_rd_rsp_ready;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    act_rf_ni_read_ctrl #(.RSP_DEPTH(RSP_DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .ni_rd_req_valid   (ni_rd_req_valid),
        .ni_rd_req_addr    (ni_rd_req_addr),
        .ni_rd_req_ready   (ni_rd_req_ready),
        .comp_en_add       (comp_en_add),
        .ni_read_rqst      (ni_read_rqst),
        .ni_read_addr      (ni_read_addr),
        .out_act_read_data (out_act_read_data),
        .ni_rd_rsp_valid   (ni_rd_rsp_valid),
        .ni_rd_rsp_data    (ni_rd_rsp_data),
        .ni_rd_rsp_addr    (ni_rd_rsp_addr),
        .ni_rd_rsp_ready   (ni_rd_rsp_ready)
    );

    // ---------------- RF model ----------------
    function automatic logic [ACT_W-1:0] rf_fn(input logic [ACT_NO_W-1:0] a);
        return a ^ 8'hA0;
    endfunction

    logic                rf_en_s;
    logic [ACT_NO_W-1:0] rf_addr_s;

    always @(negedge clk) begin
        rf_en_s   <= ni_read_rqst && (comp_en_add == COMP_EN_IDLE);
        rf_addr_s <= ni_read_addr;
    end

    // When ADD owns the port the RF returns ADD's data: model it as garbage.
    always @(posedge clk) begin
        out_act_read_data <= rf_en_s ? rf_fn(rf_addr_s) : 8'($urandom_range(0, 255));
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ni_rd_req_valid = 1'b1;
        ni_rd_req_addr = 8'h11;
        comp_en_add = COMP_EN_IDLE;
        ni_rd_rsp_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (ni_read_rqst !== 1'b0) begin errors++; $display("FAIL reset_rqst: got %0b want 0", ni_read_rqst); end
        checks++; if (ni_read_addr !== 8'h00) begin errors++; $display("FAIL reset_read_addr: got %0h want 0", ni_read_addr); end
        checks++; if (ni_rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", ni_rd_rsp_valid); end
        checks++; if (ni_rd_rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %0h want 0", ni_rd_rsp_data); end
        checks++; if (ni_rd_rsp_addr !== 8'h00) begin errors++; $display("FAIL reset_rsp_addr: got %0h want 0", ni_rd_rsp_addr); end
        checks++; if (ni_rd_req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %0b want 0", ni_rd_req_ready); end
        tick();
        rst = 1'b0;
        ni_rd_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (ni_rd_req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0b want 1", ni_rd_req_ready); end
    endtask

    task automatic test_single_read(input logic [ACT_NO_W-1:0] a, input logic [ACT_W-1:0] d);
        tick();
        ni_rd_req_valid = 1'b1;
        ni_rd_req_addr = a;
        comp_en_add = COMP_EN_IDLE;
        ni_rd_rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (ni_rd_req_ready !== 1'b1) begin errors++; $display("FAIL single_accept: got %0b want 1", ni_rd_req_ready); end
        tick();
        ni_rd_req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({ni_read_rqst, ni_read_addr} !== {1'b1, a}) begin errors++; $display("FAIL single_rqst: got rqst=%0b addr=%0h want 1/%0h", ni_read_rqst, ni_read_addr, a); end
        tick();
        @(negedge clk);
        checks++; if (ni_rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %0b want 0", ni_rd_rsp_valid); end
        tick();
        @(negedge clk);
        checks++; if ({ni_rd_rsp_valid, ni_rd_rsp_addr, ni_rd_rsp_data} !== {1'b1, a, d}) begin errors++; $display("FAIL single_rsp: got v=%0b a=%0h d=%0h want 1/%0h/%0h", ni_rd_rsp_valid, ni_rd_rsp_addr, ni_rd_rsp_data, a, d); end
        tick();
        @(negedge clk);
        checks++; if (ni_rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %0b want 0", ni_rd_rsp_valid); end
    endtask

    task automatic test_add_stall();
        tick();
        ni_rd_req_valid = 1'b1;
        ni_rd_req_addr = 8'd9;
        comp_en_add = COMP_EN_IDLE;
        ni_rd_rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (ni_rd_req_ready !== 1'b1) begin errors++; $display("FAIL stall_accept: got %0b want 1", ni_rd_req_ready); end
        // ADD becomes active in the same cycle pend rises.
        for (int i = 0; i < 4; i++) begin
            tick();
            comp_en_add = ADD_ACTIVE;
            ni_rd_req_addr = 8'h0A;
            @(negedge clk);
            checks++; if ({ni_read_rqst, ni_read_addr} !== {1'b1, 8'd9}) begin errors++; $display("FAIL stall_hold%0d: got rqst=%0b addr=%0h want 1/9", i, ni_read_rqst, ni_read_addr); end
            checks++; if (ni_rd_req_ready !== 1'b0) begin errors++; $display("FAIL stall_no_accept%0d: got %0b want 0", i, ni_rd_req_ready); end
        end
        tick();
        comp_en_add = COMP_EN_IDLE;
        ni_rd_req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({ni_read_rqst, ni_read_addr} !== {1'b1, 8'd9}) begin errors++; $display("FAIL stall_grant: got rqst=%0b addr=%0h want 1/9", ni_read_rqst, ni_read_addr); end
        tick();
        @(negedge clk);
        checks++; if (ni_rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_early_rsp: got %0b want 0", ni_rd_rsp_valid); end
        tick();
        @(negedge clk);
        checks++; if ({ni_rd_rsp_valid, ni_rd_rsp_addr, ni_rd_rsp_data} !== {1'b1, 8'd9, 8'hA9}) begin errors++; $display("FAIL stall_rsp: got v=%0b a=%0h d=%0h want 1/9/a9", ni_rd_rsp_valid, ni_rd_rsp_addr, ni_rd_rsp_data); end
    endtask

    task automatic test_back_to_back();
        logic [ACT_NO_W-1:0] ea;
        ni_rd_rsp_ready = 1'b1;
        comp_en_add = COMP_EN_IDLE;
        for (int c = 0; c < 12; c++) begin
            tick();
            ni_rd_req_valid = (c < 8);
            ni_rd_req_addr = 8'(c);
            @(negedge clk);
            if (c < 8) begin
                checks++; if (ni_rd_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d: got %0b want 1", c, ni_rd_req_ready); end
            end
            ea = 8'(c - 3);
            if (c >= 3 && c < 11) begin
                checks++; if ({ni_rd_rsp_valid, ni_rd_rsp_addr, ni_rd_rsp_data} !== {1'b1, ea, ea ^ 8'hA0}) begin errors++; $display("FAIL b2b_rsp%0d: got v=%0b a=%0h d=%0h want 1/%0h/%0h", c, ni_rd_rsp_valid, ni_rd_rsp_addr, ni_rd_rsp_data, ea, ea ^ 8'hA0); end
            end else begin
                checks++; if (ni_rd_rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d: got %0b want 0", c, ni_rd_rsp_valid); end
            end
        end
    endtask

    task automatic test_full();
        int acc = 0;
        logic [15:0] e;
        exp_q.delete();
        ni_rd_rsp_ready = 1'b0;
        comp_en_add = COMP_EN_IDLE;
        for (int c = 0; c < 10; c++) begin
            tick();
            ni_rd_req_valid = 1'b1;
            ni_rd_req_addr = 8'h20 + 8'(acc);
            @(negedge clk);
            if (ni_rd_req_ready) begin
                acc++;
                exp_q.push_back({ni_rd_req_addr, ni_rd_req_addr ^ 8'hA0});
            end
        end
        checks++; if (acc !== 4) begin errors++; $display("FAIL full_accepts: got %0d want 4", acc); end
        checks++; if (ni_rd_req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", ni_rd_req_ready); end
        // One-cycle rsp_ready: a pop and an accept share the cycle.
        tick();
        ni_rd_rsp_ready = 1'b1;
        ni_rd_req_addr = 8'h24;
        @(negedge clk);
        checks++; if (ni_rd_req_ready !== 1'b1) begin errors++; $display("FAIL full_pop_accept: got %0b want 1", ni_rd_req_ready); end
        checks++; if ({ni_rd_rsp_valid, ni_rd_rsp_addr, ni_rd_rsp_data} !== {1'b1, 8'h20, 8'h80}) begin errors++; $display("FAIL full_head: got v=%0b a=%0h d=%0h want 1/20/80", ni_rd_rsp_valid, ni_rd_rsp_addr, ni_rd_rsp_data); end
        void'(exp_q.pop_front());
        exp_q.push_back({8'h24, 8'h84});
        tick();
        ni_rd_rsp_ready = 1'b0;
        ni_rd_req_addr = 8'h25;
        @(negedge clk);
        checks++; if (ni_rd_req_ready !== 1'b0) begin errors++; $display("FAIL full_again: got %0b want 0", ni_rd_req_ready); end
        ni_rd_req_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            ni_rd_req_valid = 1'b0;
            ni_rd_rsp_ready = 1'b1;
            @(negedge clk);
            if (ni_rd_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL full_extra_rsp: got a=%0h with nothing expected", ni_rd_rsp_addr);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if ({ni_rd_rsp_addr, ni_rd_rsp_data} !== e) begin errors++; $display("FAIL full_drain_data: got %0h/%0h want %0h/%0h", ni_rd_rsp_addr, ni_rd_rsp_data, e[15:8], e[7:0]); end
                end
            end
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL full_drain_left: got %0d entries left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        tick();
        ni_rd_req_valid = 1'b1;
        ni_rd_req_addr = 8'd3;
        comp_en_add = COMP_EN_IDLE;
        ni_rd_rsp_ready = 1'b1;
        tick();
        ni_rd_req_valid = 1'b0;
        @(negedge clk);
        checks++; if ({ni_read_rqst, ni_read_addr} !== {1'b1, 8'd3}) begin errors++; $display("FAIL rmid_grant: got rqst=%0b addr=%0h want 1/3", ni_read_rqst, ni_read_addr); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({ni_read_rqst, ni_rd_rsp_valid} !== 2'b00) begin errors++; $display("FAIL rmid_in_reset: got rqst=%0b rsp_valid=%0b want 0/0", ni_read_rqst, ni_rd_rsp_valid); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ni_rd_rsp_valid) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_ghost_rsp: got a response, want none"); end
        test_single_read(8'd4, 8'hA4);
    endtask

    task automatic test_random();
        int sent = 0;
        int cycles = 0;
        int occ_m = 0;
        int max_occ = 0;
        bit hold = 1'b0;
        logic [15:0] prev = '0;
        logic [15:0] e;
        exp_q.delete();
        while (sent < 10000 && cycles < 60000) begin
            tick();
            cycles++;
            comp_en_add = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : COMP_EN_IDLE;
            ni_rd_rsp_ready = ($urandom_range(0, 3) != 0);
            ni_rd_req_valid = ($urandom_range(0, 9) != 0);
            ni_rd_req_addr = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (hold) begin
                checks++; if ({ni_rd_rsp_valid, ni_rd_rsp_addr, ni_rd_rsp_data} !== {1'b1, prev}) begin errors++; $display("FAIL rnd_stable: got v=%0b %0h/%0h want 1/%0h/%0h", ni_rd_rsp_valid, ni_rd_rsp_addr, ni_rd_rsp_data, prev[15:8], prev[7:0]); end
            end
            if (ni_rd_rsp_valid && ni_rd_rsp_ready) begin
                occ_m--;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rnd_extra_rsp: got a=%0h with nothing expected", ni_rd_rsp_addr);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if ({ni_rd_rsp_addr, ni_rd_rsp_data} !== e) begin errors++; $display("FAIL rnd_rsp: got %0h/%0h want %0h/%0h", ni_rd_rsp_addr, ni_rd_rsp_data, e[15:8], e[7:0]); end
                end
            end
            if (ni_rd_req_valid && ni_rd_req_ready) begin
                exp_q.push_back({ni_rd_req_addr, rf_fn(ni_rd_req_addr)});
                sent++;
                occ_m++;
            end
            if (occ_m > max_occ) max_occ = occ_m;
            hold = ni_rd_rsp_valid && !ni_rd_rsp_ready;
            prev = {ni_rd_rsp_addr, ni_rd_rsp_data};
        end
        checks++; if (sent !== 10000) begin errors++; $display("FAIL rnd_budget: got %0d requests want 10000", sent); end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            tick();
            ni_rd_req_valid = 1'b0;
            comp_en_add = COMP_EN_IDLE;
            ni_rd_rsp_ready = 1'b1;
            @(negedge clk);
            if (ni_rd_rsp_valid) begin
                occ_m--;
                e = exp_q.pop_front();
                checks++; if ({ni_rd_rsp_addr, ni_rd_rsp_data} !== e) begin errors++; $display("FAIL rnd_drain: got %0h/%0h want %0h/%0h", ni_rd_rsp_addr, ni_rd_rsp_data, e[15:8], e[7:0]); end
            end
        end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rnd_left: got %0d outstanding want 0", exp_q.size()); end
        checks++; if (max_occ > RSP_DEPTH) begin errors++; $display("FAIL rnd_occ: got max %0d want <= %0d", max_occ, RSP_DEPTH); end
        checks++; if (occ_m !== 0) begin errors++; $display("FAIL rnd_occ_end: got %0d want 0", occ_m); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        ni_rd_req_valid = 1'b0;
        ni_rd_req_addr = '0;
        comp_en_add = COMP_EN_IDLE;
        ni_rd_rsp_ready = 1'b0;
        test_reset();
        test_single_read(8'd5, 8'hA5);
        test_add_stall();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
